// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared slot state encoding, tile geometry defaults and coordinate helpers.
package bomberman_pkg;
    localparam int COORD_W = 10;
    localparam int TILE_SHIFT_DEF = 5;
    typedef enum logic [1:0] {FREE = 2'd0, ARMED = 2'd1, PENDING = 2'd2} slot_state_t;
    function automatic logic [COORD_W-1:0] snap(input logic [COORD_W-1:0] c, input int sh);
        return (c >> sh) << sh;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    logic [PW-1:0] idx;
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt = '0;
                gnt[idx] = 1'b1;
            end
        end
        valid = |req;
    end
endmodule

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: bomb slot array with per-slot fuses, serialising expiries onto
// the shared explosion path and producing a registered per-pixel bomb_on.
module bomb_scheduler import bomberman_pkg::*; #(
    parameter int N_SLOTS = 4,
    parameter int FUSE_TICKS = 150,
    parameter int TILE_SHIFT = TILE_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               place,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [2:0]         max_bombs,
    input  logic               tick,
    input  logic               explosion_busy,
    input  logic [COORD_W-1:0] v_x,
    input  logic [COORD_W-1:0] v_y,
    output logic [COORD_W-1:0] exploding_bomb_x,
    output logic [COORD_W-1:0] exploding_bomb_y,
    output logic               explosion_write_enable,
    output logic               bomb_on,
    output logic [3:0]         bomb_count
);
    localparam int FW = $clog2(FUSE_TICKS + 1);
    localparam int PW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    slot_state_t        st [N_SLOTS];
    slot_state_t        st_n [N_SLOTS];
    logic [COORD_W-1:0] tx [N_SLOTS];
    logic [COORD_W-1:0] ty [N_SLOTS];
    logic [COORD_W-1:0] tx_n [N_SLOTS];
    logic [COORD_W-1:0] ty_n [N_SLOTS];
    logic [FW-1:0]      fuse [N_SLOTS];
    logic [FW-1:0]      fuse_n [N_SLOTS];
    logic [PW-1:0]      ptr, ptr_n, gidx, fidx;
    logic [N_SLOTS-1:0] req, gnt;
    logic [3:0]         cap, used, cnt_n;
    logic [COORD_W-1:0] px, py;
    logic               gvalid, dup, found, accept, issue, bon_n;

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) req[i] = (st[i] == PENDING);
    end

    rr_arbiter #(.N(N_SLOTS), .PW(PW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .gnt   (gnt),
        .valid (gvalid)
    );

    // Placement and freedom are judged on registered state only.
    always_comb begin
        cap = (max_bombs == 3'd0) ? 4'd1
            : (({1'b0, max_bombs} > 4'(N_SLOTS)) ? 4'(N_SLOTS) : {1'b0, max_bombs});
        px = snap(b_x, TILE_SHIFT);
        py = snap(b_y, TILE_SHIFT);
        used = '0;
        dup = 1'b0;
        found = 1'b0;
        fidx = '0;
        gidx = '0;
        bon_n = 1'b0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (st[i] != FREE) begin
                used = used + 4'd1;
                dup = dup | (tx[i] == px && ty[i] == py);
                bon_n = bon_n | (tx[i] == snap(v_x, TILE_SHIFT) && ty[i] == snap(v_y, TILE_SHIFT));
            end else if (!found && 4'(i) < cap) begin
                found = 1'b1;
                fidx = PW'(i);
            end
            if (gnt[i]) gidx = PW'(i);
        end
        accept = place && used < cap && !dup && found;
        issue = !explosion_busy && gvalid;
        cnt_n = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            st_n[i] = st[i];
            fuse_n[i] = fuse[i];
            tx_n[i] = tx[i];
            ty_n[i] = ty[i];
            if (tick && st[i] == ARMED) begin
                fuse_n[i] = fuse[i] - 1'b1;
                if (fuse[i] == FW'(1)) st_n[i] = PENDING;
            end
            if (issue && gnt[i]) st_n[i] = FREE;
            if (accept && fidx == PW'(i)) begin
                st_n[i] = ARMED;
                fuse_n[i] = FW'(FUSE_TICKS);
                tx_n[i] = px;
                ty_n[i] = py;
            end
            if (st_n[i] != FREE) cnt_n = cnt_n + 4'd1;
        end
        ptr_n = issue ? ((gidx == PW'(N_SLOTS - 1)) ? '0 : gidx + 1'b1) : ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st[i] <= FREE;
                fuse[i] <= '0;
                tx[i] <= '0;
                ty[i] <= '0;
            end
            ptr <= '0;
            exploding_bomb_x <= '0;
            exploding_bomb_y <= '0;
            explosion_write_enable <= 1'b0;
            bomb_on <= 1'b0;
            bomb_count <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                st[i] <= st_n[i];
                fuse[i] <= fuse_n[i];
                tx[i] <= tx_n[i];
                ty[i] <= ty_n[i];
            end
            ptr <= ptr_n;
            if (issue) begin
                exploding_bomb_x <= tx[gidx];
                exploding_bomb_y <= ty[gidx];
            end
            explosion_write_enable <= issue;
            bomb_on <= bon_n;
            bomb_count <= cnt_n;
        end
    end
endmodule

// File: tb/tb_bomb_scheduler.sv
// tb_bomb_scheduler: directed vector table plus hand-written fuse, arbitration and reset sequences.
module tb_bomb_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       place = 1'b0;
    logic [9:0] b_x = '0, b_y = '0, v_x = '0, v_y = '0;
    logic [2:0] max_bombs = 3'd1;
    logic       tick = 1'b0;
    logic       explosion_busy = 1'b0;
    logic [9:0] exploding_bomb_x, exploding_bomb_y;
    logic       explosion_write_enable, bomb_on;
    logic [3:0] bomb_count;
    int         checks = 0;
    int         failures = 0;

    bomb_scheduler dut (
        .clk                    (clk),
        .reset                  (reset),
        .place                  (place),
        .b_x                    (b_x),
        .b_y                    (b_y),
        .max_bombs              (max_bombs),
        .tick                   (tick),
        .explosion_busy         (explosion_busy),
        .v_x                    (v_x),
        .v_y                    (v_y),
        .exploding_bomb_x       (exploding_bomb_x),
        .exploding_bomb_y       (exploding_bomb_y),
        .explosion_write_enable (explosion_write_enable),
        .bomb_on                (bomb_on),
        .bomb_count             (bomb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pl;
        logic [9:0] bx, by;
        logic [2:0] mb;
        logic [9:0] vx, vy;
        logic [3:0] cnt;
        logic       on;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [9:0] x, input logic [9:0] y);
        place = 1'b1; b_x = x; b_y = y;
        step();
        place = 1'b0;
    endtask

    initial begin
        logic [9:0] ex [4];
        logic [9:0] ey [4];
        ex = '{10'd32, 10'd64, 10'd96, 10'd128};
        ey = '{10'd32, 10'd32, 10'd32, 10'd64};
        tbl[0] = '{1'b1, 10'd32,  10'd32, 3'd2, 10'd0,   10'd0,  4'd1, 1'b0};
        tbl[1] = '{1'b1, 10'd64,  10'd32, 3'd2, 10'd40,  10'd40, 4'd2, 1'b1};
        tbl[2] = '{1'b1, 10'd96,  10'd32, 3'd2, 10'd100, 10'd40, 4'd2, 1'b0};
        tbl[3] = '{1'b1, 10'd40,  10'd40, 3'd4, 10'd70,  10'd33, 4'd2, 1'b1};
        tbl[4] = '{1'b1, 10'd96,  10'd32, 3'd4, 10'd100, 10'd40, 4'd3, 1'b0};
        tbl[5] = '{1'b0, 10'd0,   10'd0,  3'd4, 10'd100, 10'd40, 4'd3, 1'b1};
        tbl[6] = '{1'b0, 10'd0,   10'd0,  3'd4, 10'd128, 10'd40, 4'd3, 1'b0};
        tbl[7] = '{1'b1, 10'd128, 10'd64, 3'd0, 10'd130, 10'd70, 4'd3, 1'b0};
        tbl[8] = '{1'b1, 10'd128, 10'd64, 3'd7, 10'd0,   10'd0,  4'd4, 1'b0};
        tbl[9] = '{1'b1, 10'd160, 10'd64, 3'd7, 10'd130, 10'd70, 4'd4, 1'b1};

        #3 reset = 1'b1;
        #1;
        chk("rst_count", 32'(bomb_count), 0);
        chk("rst_we", 32'(explosion_write_enable), 0);
        chk("rst_on", 32'(bomb_on), 0);
        chk("rst_ex", 32'(exploding_bomb_x), 0);
        chk("rst_ey", 32'(exploding_bomb_y), 0);
        step();
        reset = 1'b0;

        // single bomb, placed on a tick cycle so the fuse must not count that tick
        max_bombs = 3'd1; v_x = 10'd64; v_y = 10'd32; tick = 1'b1;
        put(10'd70, 10'd40);
        chk("t1_count", 32'(bomb_count), 1);
        for (int i = 0; i < 149; i++) begin
            step();
            chk("t1_fuse_we", 32'(explosion_write_enable), 0);
        end
        chk("t1_on", 32'(bomb_on), 1);
        chk("t1_count_armed", 32'(bomb_count), 1);
        step();
        chk("t1_pending_we", 32'(explosion_write_enable), 0);
        tick = 1'b0;
        step();
        chk("t1_we", 32'(explosion_write_enable), 1);
        chk("t1_ex", 32'(exploding_bomb_x), 64);
        chk("t1_ey", 32'(exploding_bomb_y), 32);
        chk("t1_count_after", 32'(bomb_count), 0);
        step();
        chk("t1_we_off", 32'(explosion_write_enable), 0);
        chk("t1_ex_hold", 32'(exploding_bomb_x), 64);

        reset = 1'b1;
        step();
        reset = 1'b0;

        for (int r = 0; r < 10; r++) begin
            place = tbl[r].pl; b_x = tbl[r].bx; b_y = tbl[r].by; max_bombs = tbl[r].mb;
            v_x = tbl[r].vx; v_y = tbl[r].vy;
            step();
            chk($sformatf("tbl%0d_count", r), 32'(bomb_count), 32'(tbl[r].cnt));
            chk($sformatf("tbl%0d_on", r), 32'(bomb_on), 32'(tbl[r].on));
            chk($sformatf("tbl%0d_we", r), 32'(explosion_write_enable), 0);
        end
        place = 1'b0;

        // all four slots expire on the same tick and drain in slot order
        tick = 1'b1;
        for (int i = 0; i < 150; i++) step();
        tick = 1'b0;
        chk("rr_pending_we", 32'(explosion_write_enable), 0);
        chk("rr_pending_count", 32'(bomb_count), 4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr%0d_we", k), 32'(explosion_write_enable), 1);
            chk($sformatf("rr%0d_ex", k), 32'(exploding_bomb_x), 32'(ex[k]));
            chk($sformatf("rr%0d_ey", k), 32'(exploding_bomb_y), 32'(ey[k]));
            chk($sformatf("rr%0d_count", k), 32'(bomb_count), 32'(3 - k));
        end
        step();
        chk("rr_done_we", 32'(explosion_write_enable), 0);

        // busy holds two pending bombs; release drains them slot 0 then slot 1
        explosion_busy = 1'b1; max_bombs = 3'd4;
        put(10'd0, 10'd0);
        put(10'd32, 10'd0);
        chk("busy_count", 32'(bomb_count), 2);
        tick = 1'b1;
        for (int i = 0; i < 150; i++) step();
        tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("busy_hold_we", 32'(explosion_write_enable), 0);
        end
        chk("busy_hold_count", 32'(bomb_count), 2);
        explosion_busy = 1'b0;
        step();
        chk("busy_rel_we0", 32'(explosion_write_enable), 1);
        chk("busy_rel_ex0", 32'(exploding_bomb_x), 0);
        step();
        chk("busy_rel_we1", 32'(explosion_write_enable), 1);
        chk("busy_rel_ex1", 32'(exploding_bomb_x), 32);
        chk("busy_rel_ey1", 32'(exploding_bomb_y), 0);
        step();
        chk("busy_rel_done", 32'(explosion_write_enable), 0);
        chk("busy_rel_count", 32'(bomb_count), 0);

        // reset with one PENDING and two ARMED bombs
        explosion_busy = 1'b1;
        put(10'd0, 10'd64);
        tick = 1'b1;
        for (int i = 0; i < 150; i++) step();
        tick = 1'b0;
        put(10'd32, 10'd64);
        put(10'd64, 10'd64);
        v_x = 10'd0; v_y = 10'd64;
        step();
        chk("pre_rst_count", 32'(bomb_count), 3);
        chk("pre_rst_on", 32'(bomb_on), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 32'(bomb_count), 0);
        chk("async_rst_on", 32'(bomb_on), 0);
        chk("async_rst_we", 32'(explosion_write_enable), 0);
        chk("async_rst_ex", 32'(exploding_bomb_x), 0);
        chk("async_rst_ey", 32'(exploding_bomb_y), 0);
        step();
        reset = 1'b0;
        explosion_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_we", 32'(explosion_write_enable), 0);
            chk("post_rst_count", 32'(bomb_count), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
- Owns all bomb slots in the game and schedules their detonations onto the single shared explosion path (explosion renderer and box_top destruction input).
- Accepts placement requests from the centre button at the bomberman's tile and runs a per-slot fuse.
- Serialises fuse expiries into one-cycle explosion_write_enable pulses, gated by the explosion path's busy flag.
- Provides a registered per-pixel bomb_on for the top-level VGA layer mux; replaces the single-bomb path.

Parameters:
- N_SLOTS, 4, number of bomb slots (1..8)
- FUSE_TICKS, 150, tick pulses from ARMED to PENDING (>=1)
- TILE_SHIFT, 5, log2 tile size in pixels; coordinates snap to tile by clearing the low TILE_SHIFT bits

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- place  in  1  single-cycle placement request (debounced centre button SCEN)
- b_x  in  10  bomberman pixel x
- b_y  in  10  bomberman pixel y
- max_bombs  in  3  runtime capacity; 0 treated as 1; clamped to N_SLOTS
- tick  in  1  fuse timebase enable pulse
- explosion_busy  in  1  shared explosion path cannot accept a new event
- v_x  in  10  VGA hCount
- v_y  in  10  VGA vCount
- exploding_bomb_x  out  10  tile-snapped x of last issued explosion
- exploding_bomb_y  out  10  tile-snapped y of last issued explosion
- explosion_write_enable  out  1  one-cycle issue strobe
- bomb_on  out  1  pixel (v_x,v_y) lies in a tile holding an ARMED or PENDING bomb
- bomb_count  out  4  number of non-FREE slots

Behaviour:
- Reset (async, active-high): all slots FREE, fuse counters 0, round-robin pointer 0. Outputs exploding_bomb_x/y=0, explosion_write_enable=0, bomb_on=0, bomb_count=0. Reset mid-operation drops all bombs; no strobe is emitted for them.
- Per-slot state machine: FREE -> ARMED -> PENDING -> FREE. Each slot stores tile_x and tile_y (10 bits, low TILE_SHIFT bits zero) and a fuse counter.
- Placement, evaluated on the cycle place=1:
  - cap = clamp(max(max_bombs,1), N_SLOTS).
  - Target tile = {b_x,b_y} with low TILE_SHIFT bits cleared.
  - Accepted only if the non-FREE count is < cap, no non-FREE slot already holds the target tile, and a FREE slot with index < cap exists.
  - The lowest-index FREE slot below cap is loaded: state ARMED, fuse = FUSE_TICKS, visible at cycle n+1.
  - A rejected placement is dropped silently; there is no queueing.
  - Freedom is judged on registered state: a slot freed by an issue in the same cycle is not reusable until the next cycle.
  - Slots at index >= cap (after a max_bombs drop) keep running but are never newly loaded.
- Fuse:
  - On tick while ARMED: fuse decrements.
  - On the tick where fuse==1: fuse goes to 0 and state goes to PENDING, i.e. exactly FUSE_TICKS ticks after arming.
  - tick and place in the same cycle: the new slot's fuse is loaded and is not decremented that cycle.
- Issue arbitration:
  - Each cycle with explosion_busy=0 and at least one PENDING slot, grant the first PENDING slot at or after the round-robin pointer (wrapping modulo N_SLOTS).
  - Next cycle: explosion_write_enable=1 for exactly one cycle; exploding_bomb_x/y = granted tile; granted slot becomes FREE; pointer = granted index + 1 mod N_SLOTS.
  - exploding_bomb_x/y hold their value until the next issue.
  - explosion_busy=1: no grant; PENDING slots wait indefinitely and their order is preserved.
  - At most one issue per cycle. Back-to-back issues are allowed when busy stays 0: strobes on consecutive cycles.
- bomb_on:
  - Registered, 1-cycle latency from v_x/v_y.
  - Asserted when (v_x>>TILE_SHIFT, v_y>>TILE_SHIFT) equals any ARMED or PENDING slot's tile index.
- bomb_count: registered population count of non-FREE slots, updated the same cycle as the state change.
- Width rules:
  - All coordinate compares are 10-bit unsigned.
  - The fuse counter is clog2(FUSE_TICKS+1) bits and never wraps: a tick at 0 in a non-ARMED state is ignored.

Decomposition:
- Shared package (bomberman_pkg): slot state encoding (FREE=2'd0, ARMED=2'd1, PENDING=2'd2), TILE_SHIFT default, and the coordinate width constant (10).
- One sub-module, rr_arbiter: N-bit request vector plus pointer in, one-hot grant and a valid flag out, combinational.
- Slot array and fuse logic stay in bomb_scheduler.

Test Plan:
- Reset, then place at b=(70,40) with max_bombs=1 -> next cycle bomb_count=1 and slot tile=(64,32). After 150 ticks: one strobe with exploding_bomb=(64,32), then bomb_count=0.
- max_bombs=2: three places at tiles (32,32), (64,32), (96,32) -> third rejected, bomb_count=2. A place at (40,40), which falls in tile (32,32), is also rejected as a duplicate tile.
- Four bombs reach PENDING on the same tick with explosion_busy=0 -> strobes on 4 consecutive cycles in slot order 0,1,2,3, and the pointer ends at 0.
- Two PENDING bombs with explosion_busy=1 for 20 cycles -> no strobe. busy falls -> strobe 1 cycle later, second strobe the following cycle.
- v_x=100, v_y=40 with a bomb at tile (96,32) -> bomb_on=1 one cycle later. v_x=128 -> bomb_on=0.
- Assert reset while 2 bombs are ARMED and 1 is PENDING -> all outputs 0 immediately, and no strobe after reset releases.
